// File: rtl/usr_seq_ctrl.sv
// Command sequencer for an N-bit universal shift register: serialises load/shift commands into USR controls.
// Optional readback of the USR output on completion is enabled with USR_SEQ_CTRL_READBACK_EN.
module usr_seq_ctrl #(
    parameter int N  = 4,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [CW-1:0] cmd_amt,
    input  logic [N-1:0]  cmd_data,
    input  logic          abort,
    output logic [N-1:0]  usr_d,
    output logic          usr_L,
    output logic          usr_S,
    output logic          busy,
    output logic          done,
    output logic          done_aborted,
    output logic [CW:0]   shift_cnt
`ifdef USR_SEQ_CTRL_READBACK_EN
    ,
    input  logic [N-1:0]  usr_q,
    output logic [N-1:0]  rsp_data
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_SHR  = 2'b11;
    localparam logic [CW:0] LP_N   = (CW+1)'(N);

    state_t        r_state;
    state_t        w_next;
    logic          r_dirRight;
    logic [N-1:0]  r_data;
    logic [CW:0]   r_amt;
    logic [CW:0]   r_cnt;
    logic          r_abort;

    logic          w_accept;
    logic [CW:0]   w_amtExt;
    logic [CW:0]   w_effAmt;
    logic [CW:0]   w_cntNext;
    logic          w_lastShift;

    assign w_accept    = cmd_valid && (r_state == ST_IDLE);
    assign w_amtExt    = {1'b0, cmd_amt};
    assign w_effAmt    = (w_amtExt > LP_N) ? LP_N : w_amtExt;
    assign w_cntNext   = r_cnt + 1'b1;
    assign w_lastShift = (w_cntNext == r_amt);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (cmd_op == OP_LOAD)
                        w_next = ST_LOAD;
                    else if (((cmd_op == OP_SHL) || (cmd_op == OP_SHR)) && (w_effAmt != '0))
                        w_next = ST_SHIFT;
                    else
                        w_next = ST_DONE;
                end
            end
            ST_LOAD:  w_next = ST_DONE;
            ST_SHIFT: begin
                if (w_lastShift || abort)
                    w_next = ST_DONE;
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_dirRight <= 1'b0;
            r_data     <= '0;
            r_amt      <= '0;
            r_cnt      <= '0;
            r_abort    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_dirRight <= cmd_op[0];
                r_amt      <= w_effAmt;
                r_cnt      <= '0;
                r_abort    <= 1'b0;
                // usr_d only changes on a load so shifts see a stable D_in
                if (cmd_op == OP_LOAD)
                    r_data <= cmd_data;
            end else if (r_state == ST_SHIFT) begin
                r_cnt   <= w_cntNext;
                r_abort <= abort && !w_lastShift;
            end
        end
    end

    assign cmd_ready    = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign done         = (r_state == ST_DONE);
    assign done_aborted = (r_state == ST_DONE) && r_abort;
    assign usr_d        = r_data;
    assign usr_L        = (r_state == ST_LOAD) || ((r_state == ST_SHIFT) && r_dirRight);
    assign usr_S        = (r_state == ST_LOAD) || ((r_state == ST_SHIFT) && !r_dirRight);
    assign shift_cnt    = r_cnt;

`ifdef USR_SEQ_CTRL_READBACK_EN
    logic [N-1:0] r_rsp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_rsp <= '0;
        else if (r_state == ST_DONE)
            r_rsp <= usr_q;
    end

    assign rsp_data = r_rsp;
`endif

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Self-checking bench for usr_seq_ctrl: table of directed commands driving a behavioural USR,
// plus hand sequences for back-to-back acceptance and reset during a shift.
module tb_usr_seq_ctrl;

    localparam int N  = 4;
    localparam int CW = 3;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [CW-1:0] cmd_amt;
    logic [N-1:0]  cmd_data;
    logic          abort;
    logic [N-1:0]  usr_d;
    logic          usr_L;
    logic          usr_S;
    logic          busy;
    logic          done;
    logic          done_aborted;
    logic [CW:0]   shift_cnt;
    logic [N-1:0]  usrQ;
`ifdef USR_SEQ_CTRL_READBACK_EN
    logic [N-1:0]  rspData;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic [1:0]    op;
        logic [CW-1:0] amt;
        logic [N-1:0]  data;
        int            abortAt;
        int            expOps;
        logic [1:0]    expLS;
        logic          expAborted;
        logic [CW:0]   expCnt;
        logic [N-1:0]  expQ;
    } vec_t;

    vec_t vecs[15];

    usr_seq_ctrl #(.N(N), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_amt      (cmd_amt),
        .cmd_data     (cmd_data),
        .abort        (abort),
        .usr_d        (usr_d),
        .usr_L        (usr_L),
        .usr_S        (usr_S),
        .busy         (busy),
        .done         (done),
        .done_aborted (done_aborted),
        .shift_cnt    (shift_cnt)
`ifdef USR_SEQ_CTRL_READBACK_EN
        ,
        .usr_q        (usrQ),
        .rsp_data     (rspData)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural USR with zero serial fill, as attached downstream of the sequencer
    always @(posedge clk or negedge rst) begin
        if (!rst)
            usrQ <= '0;
        else begin
            case ({usr_L, usr_S})
                2'b11:   usrQ <= usr_d;
                2'b01:   usrQ <= {usrQ[N-2:0], 1'b0};
                2'b10:   usrQ <= {1'b0, usrQ[N-1:1]};
                default: usrQ <= usrQ;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int  opCount;
        int  lsBad;
        int  dBad;
        logic sawDone;
        opCount = 0;
        lsBad   = 0;
        dBad    = 0;
        sawDone = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_amt   = v.amt;
        cmd_data  = v.data;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) begin
                sawDone = 1'b1;
                break;
            end
            if ({usr_L, usr_S} !== v.expLS || busy !== 1'b1) lsBad++;
            if (v.op == 2'b01 && usr_d !== v.data) dBad++;
            opCount++;
            abort = (opCount == v.abortAt);
        end
        abort = 1'b0;
        checkOutput($sformatf("v%0d done_seen", idx), 32'(sawDone), 32'd1);
        checkOutput($sformatf("v%0d op_cycles", idx), 32'(opCount), 32'(v.expOps));
        checkOutput($sformatf("v%0d ls_pattern_errs", idx), 32'(lsBad + dBad), 32'd0);
        checkOutput($sformatf("v%0d done_LS", idx), {30'd0, usr_L, usr_S}, 32'd0);
        checkOutput($sformatf("v%0d done_aborted", idx), 32'(done_aborted), 32'(v.expAborted));
        checkOutput($sformatf("v%0d shift_cnt", idx), 32'(shift_cnt), 32'(v.expCnt));
        checkOutput($sformatf("v%0d usr_q", idx), 32'(usrQ), 32'(v.expQ));
        @(negedge clk);
        checkOutput($sformatf("v%0d idle_ready", idx), {30'd0, cmd_ready, done}, 32'd2);
        checkOutput($sformatf("v%0d cnt_hold", idx), 32'(shift_cnt), 32'(v.expCnt));
`ifdef USR_SEQ_CTRL_READBACK_EN
        checkOutput($sformatf("v%0d rsp_data", idx), 32'(rspData), 32'(v.expQ));
`endif
    endtask

    initial begin
        // op, amt, data, abortAt, expOps, expLS, expAborted, expCnt, expQ
        vecs[0]  = '{2'b01, 3'd0, 4'b1011, 0, 1, 2'b11, 1'b0, 4'd0, 4'b1011};
        vecs[1]  = '{2'b01, 3'd0, 4'b0001, 0, 1, 2'b11, 1'b0, 4'd0, 4'b0001};
        vecs[2]  = '{2'b10, 3'd3, 4'b0000, 0, 3, 2'b01, 1'b0, 4'd3, 4'b1000};
        vecs[3]  = '{2'b01, 3'd0, 4'b1111, 0, 1, 2'b11, 1'b0, 4'd0, 4'b1111};
        vecs[4]  = '{2'b11, 3'd6, 4'b0000, 0, 4, 2'b10, 1'b0, 4'd4, 4'b0000};
        vecs[5]  = '{2'b01, 3'd0, 4'b0110, 0, 1, 2'b11, 1'b0, 4'd0, 4'b0110};
        vecs[6]  = '{2'b11, 3'd1, 4'b0000, 0, 1, 2'b10, 1'b0, 4'd1, 4'b0011};
        vecs[7]  = '{2'b10, 3'd7, 4'b0000, 0, 4, 2'b01, 1'b0, 4'd4, 4'b0000};
        vecs[8]  = '{2'b01, 3'd0, 4'b1001, 0, 1, 2'b11, 1'b0, 4'd0, 4'b1001};
        vecs[9]  = '{2'b10, 3'd5, 4'b0000, 2, 2, 2'b01, 1'b1, 4'd2, 4'b0100};
        vecs[10] = '{2'b11, 3'd2, 4'b0000, 2, 2, 2'b10, 1'b0, 4'd2, 4'b0001};
        vecs[11] = '{2'b01, 3'd0, 4'b1100, 1, 1, 2'b11, 1'b0, 4'd0, 4'b1100};
        vecs[12] = '{2'b11, 3'd0, 4'b0000, 0, 0, 2'b00, 1'b0, 4'd0, 4'b1100};
        vecs[13] = '{2'b00, 3'd5, 4'b0101, 1, 0, 2'b00, 1'b0, 4'd0, 4'b1100};
        vecs[14] = '{2'b10, 3'd4, 4'b0000, 0, 4, 2'b01, 1'b0, 4'd4, 4'b0000};

        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_amt   = '0;
        cmd_data  = '0;
        abort     = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_ctrl", {27'd0, usr_L, usr_S, busy, done, done_aborted}, 32'd0);
        checkOutput("reset_ready", 32'(cmd_ready), 32'd1);
        checkOutput("reset_cnt_d", {24'd0, 4'(shift_cnt), usr_d}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 15; i++)
            applyStimulus(vecs[i], i);

        // NOP then SHR 0 with cmd_valid held: second accept waits for the return to IDLE
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        @(posedge clk);
        #1;
        cmd_op  = 2'b11;
        cmd_amt = 3'd0;
        @(negedge clk);
        checkOutput("b2b_done1", {29'd0, done, cmd_ready, usr_L | usr_S}, 32'd4);
        @(negedge clk);
        checkOutput("b2b_idle", {29'd0, done, cmd_ready, busy}, 32'd2);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_done2", {29'd0, done, done_aborted, usr_L | usr_S}, 32'd4);
        @(negedge clk);
        checkOutput("b2b_after", {29'd0, done, cmd_ready, busy}, 32'd2);

        // Reset asserted in the middle of a left shift
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_amt   = 3'd4;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_pre_S", {30'd0, usr_L, usr_S}, 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_mid_ctrl", {28'd0, usr_L, usr_S, busy, done}, 32'd0);
        checkOutput("rst_mid_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_after", {28'd0, cmd_ready, busy, done, usr_L | usr_S}, 32'd8);
        applyStimulus(vecs[0], 99);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/usr_seq_ctrl.md
Name: usr_seq_ctrl

Overview:
- Command sequencer for the N-bit universal shift register (USR): accepts load / shift-left / shift-right commands over a valid/ready handshake and drives the USR's D_in, L and S for the required number of cycles.
- Sits between a software- or FSM-driven command source and the USR instance.
- Serialises multi-bit shifts into per-cycle single shifts, saturates the shift amount and reports completion.

Parameters:
- N, 4, USR data width; must match the USR instance.
- CW, 3, width of cmd_amt; amounts 0..2^CW-1.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_op  input  2  00 NOP, 01 LOAD, 10 SHL, 11 SHR
- cmd_amt  input  CW  shift count for SHL/SHR; ignored otherwise
- cmd_data  input  N  parallel load value for LOAD
- abort  input  1  terminate an in-progress shift sequence
- usr_d  output  N  to USR D_in
- usr_L  output  1  to USR L
- usr_S  output  1  to USR S
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle completion pulse
- done_aborted  output  1  qualifies done: sequence was cut short by abort
- shift_cnt  output  CW+1  shifts issued by the last or current command

Behaviour:
- USR encoding (fixed):
  - L=1,S=1: load
  - L=0,S=1: shift left
  - L=1,S=0: shift right
  - L=0,S=0: hold
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - usr_L=0, usr_S=0, usr_d=0, cmd_ready=1, busy=0, done=0, done_aborted=0, shift_cnt=0.
  - Reset in any state drops usr_L and usr_S to 0 immediately, so no partial operation completes.
- States: IDLE, LOAD, SHIFT, DONE. All outputs are Moore, decoded from registered state and latched command; no combinational path from inputs to outputs except cmd_ready = (state==IDLE).
- IDLE:
  - usr_L=usr_S=0.
  - On cmd_valid & cmd_ready: latch op, data and eff_amt = min(cmd_amt, N); clear shift_cnt.
  - Next state:
    - LOAD: op LOAD.
    - SHIFT: op SHL/SHR with eff_amt>0.
    - DONE: op NOP, or SHL/SHR with eff_amt=0.
- LOAD: exactly one cycle, usr_L=usr_S=1, usr_d=latched data; next state DONE. abort is ignored.
- SHIFT:
  - One USR shift per cycle (SHL: L=0,S=1; SHR: L=1,S=0); usr_d holds its last value.
  - shift_cnt increments at each SHIFT-cycle edge.
  - Leaves to DONE at the edge where shift_cnt reaches eff_amt.
  - abort=1 sampled in a SHIFT cycle: that cycle's shift still counts; next state DONE with the abort flag set.
  - abort on the final shift cycle does not set the flag.
- DONE:
  - One cycle; usr_L=usr_S=0, done=1, done_aborted=flag, cmd_ready=0; next state IDLE.
  - shift_cnt holds until the next accepted command.
- Latency from accept edge:
  - LOAD: 1 operation cycle, then done.
  - SHL/SHR k: k operation cycles, then done.
  - NOP or k=0: done in the first cycle after accept.
- Throughput: one command per (operation cycles + 2) cycles; cmd_valid held during busy is accepted on return to IDLE.
- Saturation: cmd_amt > N is treated as N (register fully flushed to zero); shift_cnt reports N.
- abort outside SHIFT has no effect.

Optional Feature:
- Macro: USR_SEQ_CTRL_READBACK_EN.
- Defined:
  - Adds input usr_q [N-1:0] (USR D_out) and output rsp_data [N-1:0], reset 0.
  - rsp_data captures usr_q at the edge ending DONE.
  - It holds that value from the following IDLE cycle until the next DONE.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset: assert rst=0 mid-SHIFT with usr_S=1 -> usr_L/usr_S/busy/done drop to 0 the same cycle; cmd_ready=1; after release, IDLE.
- LOAD 4'b1011 -> one cycle usr_L=usr_S=1 with usr_d=1011, then done=1, done_aborted=0; attached USR D_out=1011.
- SHL amt 3 after LOAD 0001 -> three cycles L=0,S=1; done; shift_cnt=3; USR D_out=1000.
- SHR amt 6 (N=4) after LOAD 1111 -> exactly four cycles L=1,S=0; shift_cnt=4; USR D_out=0000.
- SHL amt 5, abort=1 in the 2nd shift cycle -> two shifts issued; done=1, done_aborted=1; shift_cnt=2.
- NOP and SHR amt 0 back-to-back with cmd_valid held -> no L/S activity; done pulses the cycle after each accept; second accept occurs on return to IDLE. With USR_SEQ_CTRL_READBACK_EN, rsp_data equals USR D_out after each done.
